iodelay_tap_ctrl: RTL
=====================

# iodelay_tap_ctrl

Parametrised multi-channel variable tap-delay element with a shared tap-control state machine. Each channel delays a 1-bit data stream by a per-channel, run-time adjustable number of CLK cycles (0..MAX_TAP). A global BUSY handshake gates tap updates, and calibration and load operations are supported. The block sits between the I/O capture registers and the deserialisers, and serves as the synthesizable, portable replacement for vendor fixed/variable delay primitives.

## Interface
- NCH, 4, number of independent delay channels (1..32)
- TAP_W, 5, tap counter width; MAX_TAP = 2**TAP_W - 1
- INIT_TAP, 0, tap value loaded on reset (0..MAX_TAP)
- WRAP, 1, 1 = counter wraps around; 0 = counter stays at limit
- CAL_HALF, 1, 1 = CAL loads MAX_TAP>>1; 0 = CAL loads 0
- BUSY_CYC, 4, number of cycles BUSY stays high after an accepted operation (1..15)

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- DATAIN  in  NCH  per-channel input data
- CE  in  NCH  per-channel tap step enable
- INC  in  NCH  per-channel step direction; 1 = increment, 0 = decrement
- LD  in  1  load LD_VAL into all channels whose CE bit is 1
- LD_VAL  in  TAP_W  load value
- CAL  in  1  calibrate: set every channel's tap to the CAL value
- DATAOUT  out  NCH  per-channel delayed data, registered
- TAP  out  NCH*TAP_W  current tap per channel; channel k is at [k*TAP_W +: TAP_W]
- BUSY  out  1  high while an operation is settling; new requests are ignored

## Operation
- Delay line: each channel has a MAX_TAP-deep shift register clocked every cycle. DATAOUT[k] = DATAIN[k] delayed by TAP[k]+1 cycles. Tap 0 means one register stage.
- FSM states:
  - IDLE: BUSY=0. Requests are sampled here. Priority is CAL > LD > CE.
    - CAL=1: all taps are set to the CAL value; go to WAIT.
    - LD=1 with any CE bit set: taps of the selected channels are set to LD_VAL; go to WAIT.
    - LD=1 with CE=0: no operation; stay in IDLE.
    - LD=0 with any CE bit set: each selected channel steps by ±1; go to WAIT.
  - WAIT: BUSY=1. A down-counter is loaded with BUSY_CYC-1. Return to IDLE when the counter reaches 0. All CAL/LD/CE inputs are ignored (not queued).
- Step arithmetic is modulo 2**TAP_W:
  - WRAP=1: MAX_TAP+1 becomes 0, and 0-1 becomes MAX_TAP.
  - WRAP=0: a step beyond MAX_TAP or below 0 holds the tap value. The operation still counts as accepted (BUSY pulses).
- Channels with different INC values step independently in the same cycle.
- A tap change does not flush the shift register. DATAOUT may repeat or skip samples on the cycle the selected tap changes.
- Reset: all taps = INIT_TAP, shift registers = 0, DATAOUT = 0, BUSY = 0, FSM = IDLE, counter = 0.
- Reset asserted mid-WAIT aborts the operation immediately (asynchronously). The first request after release is accepted on the first rising edge with RST_N high.

## Timing
- A request sampled at edge N updates TAP at edge N, so the new TAP is visible after edge N. BUSY is 1 from edge N to edge N+BUSY_CYC, then 0.
- The next request is accepted at edge N+BUSY_CYC+1 at the earliest.
- DATAOUT uses the new tap starting with the output registered at edge N+1.
- DATAIN-to-DATAOUT latency is TAP+1 cycles. No combinational paths exist from inputs to outputs.

## Configuration
- IODLY_PARAM_CHECK_EN defined: an initial block checks NCH, TAP_W (1..8), INIT_TAP, BUSY_CYC and WRAP/CAL_HALF (0/1). On a violation it does $display("ERROR : ... %m ...") and $finish.
- IODLY_PARAM_CHECK_EN undefined: no checks are made. INIT_TAP is truncated to TAP_W bits, and BUSY_CYC=0 behaves as 1.

## Test plan
- Reset with INIT_TAP=3, then drive a single 1 pulse on DATAIN[0] at edge 10 -> DATAOUT[0]=1 exactly at edge 14. TAP=3 on all channels and BUSY=0 after reset.
- WRAP=1, TAP[1]=31, CE[1]=1, INC=1 -> TAP[1]=0. BUSY is high for 4 cycles, then low.
- WRAP=0, TAP[2]=0, CE[2]=1, INC=0 -> TAP[2] stays 0 and BUSY still pulses for 4 cycles.
- CAL and LD asserted in the same cycle with CAL_HALF=1 -> all taps = 15 and LD is ignored. Then CE=4'b1111 with INC=4'b0101 -> taps become 16,14,16,14.
- A request issued while BUSY=1 -> TAP is unchanged. The same request issued one cycle after BUSY falls -> accepted.
- RST_N low two cycles into WAIT -> BUSY=0 and TAP=INIT_TAP immediately, without waiting for a clock edge. A CE pulse on the first edge after release -> accepted.

Source files
------------

// File: rtl/iodelay_tap_ctrl.sv
// Multi-channel variable tap delay line with a shared tap-control FSM (IDLE/WAIT).
// Define IODLY_PARAM_CHECK_EN to enable elaboration-time parameter checks.
module iodelay_tap_ctrl #(
    parameter int NCH      = 4,
    parameter int TAP_W    = 5,
    parameter int INIT_TAP = 0,
    parameter int WRAP     = 1,
    parameter int CAL_HALF = 1,
    parameter int BUSY_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     datain,
    input  logic [NCH-1:0]     ce,
    input  logic [NCH-1:0]     inc,
    input  logic               ld,
    input  logic [TAP_W-1:0]   ld_val,
    input  logic               cal,
    output logic [NCH-1:0]     dataout,
    output logic [NCH*TAP_W-1:0] tap,
    output logic               busy,
    output logic               state_dbg
);

    localparam int MAX_TAP = (1 << TAP_W) - 1;
    localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] CAL_T  = (CAL_HALF != 0) ? (MAX_T >> 1) : '0;

`ifdef IODLY_PARAM_CHECK_EN
    initial begin
        if (NCH < 1 || NCH > 32 || TAP_W < 1 || TAP_W > 8 ||
            INIT_TAP < 0 || INIT_TAP > MAX_TAP ||
            BUSY_CYC < 1 || BUSY_CYC > 15 ||
            (WRAP != 0 && WRAP != 1) || (CAL_HALF != 0 && CAL_HALF != 1)) begin
            $display("ERROR : illegal parameter set in %m");
            $finish;
        end
    end
    localparam int BUSY_N = BUSY_CYC;
`else
    // A zero busy length would never leave WAIT correctly; treat it as one cycle.
    localparam int BUSY_N = (BUSY_CYC < 1) ? 1 : BUSY_CYC;
`endif

    localparam logic [3:0] BUSY_LOAD = 4'(BUSY_N - 1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TAP_W-1:0] tap_q [NCH];
    logic [TAP_W-1:0] tap_d [NCH];

    // One tap step; without wrap the value saturates at either end.
    function automatic logic [TAP_W-1:0] step(input logic [TAP_W-1:0] t, input logic up);
        if (up) begin
            if (WRAP == 0 && t == MAX_T) return t;
            return t + TAP_W'(1);
        end
        if (WRAP == 0 && t == '0) return t;
        return t - TAP_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int k = 0; k < NCH; k++) tap_d[k] = tap_q[k];
        case (state_q)
            S_IDLE: begin
                if (cal) begin
                    for (int k = 0; k < NCH; k++) tap_d[k] = CAL_T;
                    state_d = S_WAIT;
                    cnt_d   = BUSY_LOAD;
                end else if (|ce) begin
                    for (int k = 0; k < NCH; k++) begin
                        if (ce[k]) tap_d[k] = ld ? ld_val : step(tap_q[k], inc[k]);
                    end
                    state_d = S_WAIT;
                    cnt_d   = BUSY_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            for (int k = 0; k < NCH; k++) tap_q[k] <= INIT_T;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NCH; k++) tap_q[k] <= tap_d[k];
        end
    end

    assign busy      = (state_q == S_WAIT);
    assign state_dbg = state_q;

    // hist[0] is the live input, hist[i] the sample taken i edges ago.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [MAX_TAP-1:0] sr;
        logic [MAX_TAP:0]   hist;
        logic               dout_r;

        assign hist = {sr, datain[k]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr     <= '0;
                dout_r <= 1'b0;
            end else begin
                sr     <= hist[MAX_TAP-1:0];
                dout_r <= hist[tap_q[k]];
            end
        end

        assign dataout[k]               = dout_r;
        assign tap[k*TAP_W +: TAP_W]    = tap_q[k];
    end

endmodule
